x_mem_responder: RTL and testbench

X_MEM_RESPONDER -- requirements
Module: x_mem_responder

---
 rtl/x_mem_responder_pkg.sv | 59 +++++
 rtl/x_mem_responder_xmem_array.sv | 29 ++
 rtl/x_mem_responder.sv | 168 ++++++++++++++++
 tb/tb_x_mem_responder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/x_mem_responder_pkg.sv
// Shared coprocessor memory-interface types for the x_mem_responder slice.
// Holds the request/response/result structs, the responder FSM encoding and
// a byte-lane merge helper used by the backing store.
package pa_rvfpm;

    localparam int X_ID_WIDTH  = 4;
    localparam int X_MEM_WIDTH = 32;
    localparam int X_BE_WIDTH  = X_MEM_WIDTH / 8;

    // Request presented by the coprocessor with mem_valid.
    typedef struct packed {
        logic [X_ID_WIDTH-1:0]  id;
        logic [31:0]            addr;
        logic                   we;
        logic [X_BE_WIDTH-1:0]  be;
        logic [X_MEM_WIDTH-1:0] wdata;
    } x_mem_req_t;

    // Immediate response returned in the handshake cycle.
    typedef struct packed {
        logic       exc;
        logic [5:0] exccode;
        logic       dbg;
    } x_mem_resp_t;

    // Deferred result returned with mem_result_valid.
    typedef struct packed {
        logic [X_ID_WIDTH-1:0]  id;
        logic [X_MEM_WIDTH-1:0] rdata;
        logic                   err;
        logic                   dbg;
    } x_mem_result_t;

    // Responder access sequencing.
    typedef enum logic [1:0] {
        XMEM_IDLE   = 2'd0,
        XMEM_WAIT   = 2'd1,
        XMEM_RESULT = 2'd2
    } xmem_state_e;

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [X_MEM_WIDTH-1:0] be_merge(
        input logic [X_MEM_WIDTH-1:0] old_word,
        input logic [X_MEM_WIDTH-1:0] new_word,
        input logic [X_BE_WIDTH-1:0]  be
    );
        logic [X_MEM_WIDTH-1:0] merged;
        merged = old_word;
        for (int b = 0; b < X_BE_WIDTH; b++) begin
            if (be[b]) begin
                merged[b*8 +: 8] = new_word[b*8 +: 8];
            end else begin
                merged[b*8 +: 8] = old_word[b*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/x_mem_responder_xmem_array.sv
// Byte-enable word storage: one synchronous write port, one asynchronous
// read port. Contents are intentionally not reset.
module xmem_array
    import pa_rvfpm::*;
#(
    parameter int WORDS = 1024,
    parameter int AW    = 10
) (
    input  logic                   clk,
    input  logic                   i_we,
    input  logic [AW-1:0]          i_waddr,
    input  logic [X_BE_WIDTH-1:0]  i_be,
    input  logic [X_MEM_WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]          i_raddr,
    output logic [X_MEM_WIDTH-1:0] o_rdata
);

    logic [X_MEM_WIDTH-1:0] r_mem [WORDS];

    // Merge enabled byte lanes into the addressed word on the clock edge.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= be_merge(r_mem[i_waddr], i_wdata, i_be);
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/x_mem_responder.sv
// Coprocessor memory responder: accepts one request at a time in IDLE,
// waits WAIT_CYCLES cycles, then performs the access and strobes the result
// for one cycle. Optional macro XMEM_RANGE_CHECK_EN flags addresses beyond
// the backing store as errors instead of wrapping them.
module x_mem_responder
    import pa_rvfpm::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  x_mem_req_t    mem_req,
    output x_mem_resp_t   mem_resp,
    output logic          mem_result_valid,
    output x_mem_result_t mem_result
);

    localparam int AW = $clog2(DEPTH_WORDS);
    // Counter preload; a zero-wait build never enters WAIT.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    xmem_state_e            r_state;
    xmem_state_e            w_state_next;
    logic [3:0]             r_cnt;
    logic [3:0]             w_cnt_next;

    logic [X_ID_WIDTH-1:0]  r_id;
    logic [31:0]            r_addr;
    logic                   r_we;
    logic [X_BE_WIDTH-1:0]  r_be;
    logic [X_MEM_WIDTH-1:0] r_wdata;

    logic                   w_handshake;
    logic                   w_oor;
    logic                   w_mem_we;
    logic [AW-1:0]          w_word_idx;
    logic [X_MEM_WIDTH-1:0] w_rdata;
    logic [1:0]             w_unused_addr_lo;

    assign w_handshake      = mem_valid && (r_state == XMEM_IDLE);
    assign w_word_idx       = r_addr[AW+1:2];
    assign w_unused_addr_lo = r_addr[1:0];

`ifdef XMEM_RANGE_CHECK_EN
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);
    assign w_oor = (r_addr >= ADDR_LIMIT);
`else
    logic [31-(AW+2):0] w_unused_addr_hi;
    assign w_unused_addr_hi = r_addr[31:AW+2];
    assign w_oor            = 1'b0;
`endif

    // Write happens in the RESULT cycle so the next accepted request sees it.
    assign w_mem_we = (r_state == XMEM_RESULT) && r_we && !w_oor;

    xmem_array #(
        .WORDS (DEPTH_WORDS),
        .AW    (AW)
    ) u_xmem_array (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (w_word_idx),
        .i_be    (r_be),
        .i_wdata (r_wdata),
        .i_raddr (w_word_idx),
        .o_rdata (w_rdata)
    );

    // State and wait counter registers; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= XMEM_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state and wait-counter sequencing.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            XMEM_IDLE: begin
                if (w_handshake) begin
                    if (WAIT_CYCLES > 0) begin
                        w_state_next = XMEM_WAIT;
                        w_cnt_next   = WAIT_LOAD;
                    end else begin
                        w_state_next = XMEM_RESULT;
                        w_cnt_next   = 4'd0;
                    end
                end else begin
                    w_state_next = XMEM_IDLE;
                    w_cnt_next   = r_cnt;
                end
            end
            XMEM_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = XMEM_RESULT;
                    w_cnt_next   = 4'd0;
                end else begin
                    w_state_next = XMEM_WAIT;
                    w_cnt_next   = r_cnt - 4'd1;
                end
            end
            XMEM_RESULT: begin
                w_state_next = XMEM_IDLE;
                w_cnt_next   = 4'd0;
            end
            default: begin
                w_state_next = XMEM_IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    // Capture the request fields at the handshake; held until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id    <= {X_ID_WIDTH{1'b0}};
            r_addr  <= 32'd0;
            r_we    <= 1'b0;
            r_be    <= {X_BE_WIDTH{1'b0}};
            r_wdata <= {X_MEM_WIDTH{1'b0}};
        end else if (w_handshake) begin
            r_id    <= mem_req.id;
            r_addr  <= mem_req.addr;
            r_we    <= mem_req.we;
            r_be    <= mem_req.be;
            r_wdata <= mem_req.wdata;
        end else begin
            r_id    <= r_id;
            r_addr  <= r_addr;
            r_we    <= r_we;
            r_be    <= r_be;
            r_wdata <= r_wdata;
        end
    end

    assign mem_ready        = (r_state == XMEM_IDLE);
    assign mem_result_valid = (r_state == XMEM_RESULT);

    // This responder never raises exceptions; the response is constant zero.
    assign mem_resp = '0;

    // Result payload, forced to zero outside the RESULT cycle.
    always_comb begin
        mem_result = '0;
        if (r_state == XMEM_RESULT) begin
            mem_result.id  = r_id;
            mem_result.err = w_oor;
            mem_result.dbg = 1'b0;
            if (r_we || w_oor) begin
                mem_result.rdata = {X_MEM_WIDTH{1'b0}};
            end else begin
                mem_result.rdata = w_rdata;
            end
        end else begin
            mem_result = '0;
        end
    end

endmodule

// File: tb/tb_x_mem_responder.sv
// Scoreboard bench: DUT A uses WAIT_CYCLES=2, DUT B uses WAIT_CYCLES=0.
module tb_x_mem_responder;
    import pa_rvfpm::*;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_a, ready_a, rv_a;
    logic          valid_b, ready_b, rv_b;
    x_mem_req_t    req_a, req_b;
    x_mem_resp_t   resp_a, resp_b;
    x_mem_result_t res_a, res_b;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    x_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut_a (
        .clk(clk), .rst(rst), .mem_valid(valid_a), .mem_ready(ready_a),
        .mem_req(req_a), .mem_resp(resp_a), .mem_result_valid(rv_a), .mem_result(res_a)
    );

    x_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut_b (
        .clk(clk), .rst(rst), .mem_valid(valid_b), .mem_ready(ready_b),
        .mem_req(req_b), .mem_resp(resp_b), .mem_result_valid(rv_b), .mem_result(res_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for DUT A: pop and compare on every result strobe.
    always @(negedge clk) begin
        if (rv_a) begin
            if (q_a.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL a_unexpected_result: got id %0d expected no result", res_a.id);
            end else begin
                e_a = q_a.pop_front();
                check("a_id",    64'(res_a.id),    64'(e_a.id));
                check("a_rdata", 64'(res_a.rdata), 64'(e_a.rdata));
                check("a_err",   64'(res_a.err),   64'(e_a.err));
                check("a_dbg",   64'(res_a.dbg),   64'd0);
                check("a_cycle", 64'(cyc),         64'(e_a.cyc));
            end
        end else begin
            check("a_idle_result_zero", 64'(res_a), 64'd0);
        end
        check("a_resp_zero", 64'(resp_a), 64'd0);
    end

    // Monitor for DUT B: pop and compare on every result strobe.
    always @(negedge clk) begin
        if (rv_b) begin
            if (q_b.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL b_unexpected_result: got id %0d expected no result", res_b.id);
            end else begin
                e_b = q_b.pop_front();
                check("b_id",    64'(res_b.id),    64'(e_b.id));
                check("b_rdata", 64'(res_b.rdata), 64'(e_b.rdata));
                check("b_err",   64'(res_b.err),   64'(e_b.err));
                check("b_cycle", 64'(cyc),         64'(e_b.cyc));
            end
        end else begin
            check("b_idle_result_zero", 64'(res_b), 64'd0);
        end
        check("b_resp_zero", 64'(resp_b), 64'd0);
    end

    // Present one request, wait (bounded) for the handshake, queue the expectation.
    task automatic issue(input bit sel, input logic [3:0] id, input logic [31:0] addr,
                         input logic we, input logic [3:0] be, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input bit expect_res, output int hs_cyc);
        x_mem_req_t r;
        exp_t       e;
        bit         got;
        r.id = id; r.addr = addr; r.we = we; r.be = be; r.wdata = wdata;
        @(negedge clk);
        if (sel) begin req_b = r; valid_b = 1'b1; end
        else     begin req_a = r; valid_a = 1'b1; end
        got = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if ((sel ? ready_b : ready_a) == 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL issue_timeout: id %0d got no ready expected ready within 50 cycles", id);
        end
        hs_cyc = cyc;
        if (expect_res) begin
            e.id = id; e.rdata = exp_rdata; e.err = exp_err;
            e.cyc = cyc + (sel ? 1 : 3);
            if (sel) q_b.push_back(e);
            else     q_a.push_back(e);
        end
        @(posedge clk);
        #1;
        if (sel) valid_b = 1'b0;
        else     valid_a = 1'b0;
    endtask

    int h1, h2, h3, hx;
    logic [31:0] exp_oor_rdata;
    logic        exp_oor_err;

    initial begin
        rst = 1'b1;
        valid_a = 1'b0; valid_b = 1'b0;
        req_a = '0; req_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ready_a", 64'(ready_a), 64'd1);
        check("reset_rv_a",    64'(rv_a),    64'd0);
        check("reset_ready_b", 64'(ready_b), 64'd1);
        check("reset_rv_b",    64'(rv_b),    64'd0);

        // Full write, ready low for three cycles, then a read right after RESULT.
        issue(1'b0, 4'd3, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("a_ready_low_during_access", 64'(ready_a), 64'd0);
        end
        issue(1'b0, 4'd4, 32'h10, 1'b0, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, h2);
        check("a_read_accepted_after_result", 64'(h2 - h1), 64'd4);

        // Partial byte write then read-back; low address bits ignored.
        issue(1'b0, 4'd5, 32'h10, 1'b1, 4'h2, 32'h0000AA00, 32'h0, 1'b0, 1'b1, hx);
        issue(1'b0, 4'd6, 32'h10, 1'b0, 4'h0, 32'h0, 32'hDEADAAEF, 1'b0, 1'b1, hx);
        issue(1'b0, 4'd7, 32'h13, 1'b0, 4'h0, 32'h0, 32'hDEADAAEF, 1'b0, 1'b1, hx);

        // Establish 0x20, then reset in the middle of an overwrite.
        issue(1'b0, 4'd8, 32'h20, 1'b1, 4'hF, 32'h11223344, 32'h0, 1'b0, 1'b1, hx);
        issue(1'b0, 4'd9, 32'h20, 1'b0, 4'h0, 32'h0, 32'h11223344, 1'b0, 1'b1, hx);
        issue(1'b0, 4'd10, 32'h20, 1'b1, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, hx);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("a_ready_after_abort", 64'(ready_a), 64'd1);
        check("a_rv_after_abort",    64'(rv_a),    64'd0);
        repeat (4) @(negedge clk);
        issue(1'b0, 4'd11, 32'h20, 1'b0, 4'h0, 32'h0, 32'h11223344, 1'b0, 1'b1, hx);

        // Address beyond the store: error or wrap depending on build.
        issue(1'b0, 4'd12, 32'h0, 1'b1, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1, hx);
`ifdef XMEM_RANGE_CHECK_EN
        exp_oor_rdata = 32'h0;
        exp_oor_err   = 1'b1;
`else
        exp_oor_rdata = 32'hCAFEF00D;
        exp_oor_err   = 1'b0;
`endif
        issue(1'b0, 4'd13, 32'h1000, 1'b0, 4'h0, 32'h0, exp_oor_rdata, exp_oor_err, 1'b1, hx);

        // Zero-wait instance: back-to-back traffic, one result every two cycles.
        issue(1'b1, 4'd1, 32'h4, 1'b1, 4'hF, 32'h12345678, 32'h0, 1'b0, 1'b1, hx);
        issue(1'b1, 4'd2, 32'h8, 1'b1, 4'hF, 32'h9ABCDEF0, 32'h0, 1'b0, 1'b1, hx);
        issue(1'b1, 4'd3, 32'h4, 1'b0, 4'h0, 32'h0, 32'h12345678, 1'b0, 1'b1, h1);
        issue(1'b1, 4'd4, 32'h8, 1'b0, 4'h0, 32'h0, 32'h9ABCDEF0, 1'b0, 1'b1, h2);
        issue(1'b1, 4'd5, 32'h4, 1'b0, 4'h0, 32'h0, 32'h12345678, 1'b0, 1'b1, h3);
        check("b_b2b_spacing_1", 64'(h2 - h1), 64'd2);
        check("b_b2b_spacing_2", 64'(h3 - h2), 64'd2);

        for (int i = 0; i < 50; i++) begin
            if (q_a.size() == 0 && q_b.size() == 0) break;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check("a_queue_drained", 64'(q_a.size()), 64'd0);
        check("b_queue_drained", 64'(q_b.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
